ex_mem_skid_reg: RTL and testbench

Parametrised EX/MEM pipeline boundary register for the five-stage core, replacing a fixed-width, always-advancing latch with an elastic valid/ready stage. It carries EX-stage results and MEM/WB controls into the MEM stage. A two-entry skid buffer lets the memory stage stall without a combinational ready path back into EX. It supports flushes, which insert bubbles, and qualifies every control output with valid so that bubbles never write memory or registers.

---
 rtl/ex_mem_skid_reg.sv | 107 ++++++++++
 tb/tb_ex_mem_skid_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM boundary register: an elastic valid/ready stage backed by a two-entry skid buffer.
// The skid entry absorbs one MEM-stage stall, so in_ready is driven only from registered state.
module ex_mem_skid_reg #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_regwrite,
    input  logic            in_memread,
    input  logic            in_memtoreg,
    input  logic            in_memwrite,
    input  logic            in_branch,
    input  logic            in_zero,
    input  logic [XLEN-1:0] in_target,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memtoreg,
    output logic            out_memwrite,
    output logic            out_branch,
    output logic            out_zero,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_alu,
    output logic [XLEN-1:0] out_wdata,
    output logic [RD_W-1:0] out_rd,
    output logic            out_pcsrc
);

    localparam int PW = 6 + 3 * XLEN + RD_W;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic [5:0]    ctl_q;
    logic          accept;
    logic          drain;

    assign in_pl = {in_regwrite, in_memread, in_memtoreg, in_memwrite, in_branch, in_zero,
                    in_target, in_alu, in_wdata, in_rd};

    assign in_ready = ~skid_vld_q;
    assign accept   = in_valid & in_ready;
    assign drain    = main_vld_q & out_ready;

    always_comb begin
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (!main_vld_q || drain) begin
            // The skid entry is older than anything on the input, so it moves first.
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_vld_d = 1'b1;
                main_d     = in_pl;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_d     = in_pl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign {ctl_q, out_target, out_alu, out_wdata, out_rd} = main_q;

    // Controls are qualified so a bubble can never write memory, registers or redirect the PC.
    assign out_valid    = main_vld_q;
    assign out_regwrite = main_vld_q & ctl_q[5];
    assign out_memread  = main_vld_q & ctl_q[4];
    assign out_memtoreg = main_vld_q & ctl_q[3];
    assign out_memwrite = main_vld_q & ctl_q[2];
    assign out_branch   = main_vld_q & ctl_q[1];
    assign out_zero     = main_vld_q & ctl_q[0];
    assign out_pcsrc    = main_vld_q & ctl_q[1] & ctl_q[0];

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: accepted entries are queued and compared against
// the main entry each cycle; occupancy of the queue predicts out_valid and in_ready.
module tb_ex_mem_skid_reg;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    typedef struct packed {
        logic            rw, mr, mtr, mw, br, z;
        logic [XLEN-1:0] tgt, alu, wd;
        logic [RD_W-1:0] rd;
    } ent_t;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, out_ready;
    logic            in_ready, out_valid, out_pcsrc;
    logic            in_regwrite, in_memread, in_memtoreg, in_memwrite, in_branch, in_zero;
    logic            out_regwrite, out_memread, out_memtoreg, out_memwrite, out_branch, out_zero;
    logic [XLEN-1:0] in_target, in_alu, in_wdata, out_target, out_alu, out_wdata;
    logic [RD_W-1:0] in_rd, out_rd;

    ent_t q[$];
    ent_t stale;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memread(in_memread), .in_memtoreg(in_memtoreg),
        .in_memwrite(in_memwrite), .in_branch(in_branch), .in_zero(in_zero),
        .in_target(in_target), .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memtoreg(out_memtoreg),
        .out_memwrite(out_memwrite), .out_branch(out_branch), .out_zero(out_zero),
        .out_target(out_target), .out_alu(out_alu), .out_wdata(out_wdata), .out_rd(out_rd),
        .out_pcsrc(out_pcsrc)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic rw, input logic mw, input logic br, input logic z,
                                input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] alu,
                                input logic [XLEN-1:0] wd, input logic [RD_W-1:0] rd);
        ent_t e;
        e.rw = rw; e.mr = mw ? 1'b0 : ~rw; e.mtr = rw & ~mw & alu[4]; e.mw = mw;
        e.br = br; e.z = z; e.tgt = tgt; e.alu = alu; e.wd = wd; e.rd = rd;
        return e;
    endfunction

    task automatic drive(input logic v, input ent_t e);
        in_valid    = v;
        in_regwrite = e.rw; in_memread = e.mr; in_memtoreg = e.mtr;
        in_memwrite = e.mw; in_branch = e.br; in_zero = e.z;
        in_target   = e.tgt; in_alu = e.alu; in_wdata = e.wd; in_rd = e.rd;
    endtask

    task automatic check_outputs();
        ent_t h;
        chk_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
        h = (q.size() > 0) ? q[0] : stale;
        chk_eq("out_target", out_target, h.tgt);
        chk_eq("out_alu", out_alu, h.alu);
        chk_eq("out_wdata", out_wdata, h.wd);
        chk_eq("out_rd", 64'(out_rd), 64'(h.rd));
        if (q.size() == 0) begin
            h.rw = 0; h.mr = 0; h.mtr = 0; h.mw = 0; h.br = 0; h.z = 0;
        end
        chk_eq("out_ctl", 64'({out_regwrite, out_memread, out_memtoreg, out_memwrite, out_branch, out_zero}),
               64'({h.rw, h.mr, h.mtr, h.mw, h.br, h.z}));
        chk_eq("out_pcsrc", 64'(out_pcsrc), 64'(h.br & h.z));
    endtask

    // One clock: check current outputs, advance the model with the driven inputs, step the edge.
    task automatic tick();
        ent_t e, popped;
        logic rdy, acc, drn;
        check_outputs();
        rdy = (q.size() < 2);
        acc = in_valid & rdy;
        drn = (q.size() > 0) & out_ready;
        e = '{in_regwrite, in_memread, in_memtoreg, in_memwrite, in_branch, in_zero,
              in_target, in_alu, in_wdata, in_rd};
        if (reset) begin
            q.delete();
            stale = '0;
        end else if (flush) begin
            if (q.size() > 0) stale = q[0];
            q.delete();
        end else begin
            if (drn) popped = q.pop_front();
            if (acc) q.push_back(e);
            if (drn && q.size() == 0) stale = popped;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ent_t e;
        stale = '0;
        reset = 1; flush = 0; out_ready = 1;
        drive(1'b1, mk(1, 1, 1, 1, 64'hAAAA, 64'h5555, 64'h1234, 5'd9));
        @(posedge clk); #1;
        q.delete(); stale = '0;
        tick();
        reset = 0;

        // Back-to-back stream with the consumer always ready.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, mk(1, 0, 0, 0, 64'h0, 64'(i * 16), 64'h0, 5'(i)));
            tick();
        end
        drive(1'b0, '0);
        tick();
        tick();

        // Store, then a stall long enough to fill the skid.
        out_ready = 0;
        drive(1'b1, mk(0, 1, 0, 0, 64'h0, 64'h200, 64'hDEADBEEF, 5'd7));
        tick();
        drive(1'b1, mk(1, 0, 0, 0, 64'h0, 64'h88, 64'h0, 5'd3));
        tick();
        drive(1'b1, mk(1, 0, 0, 0, 64'h0, 64'h99, 64'h0, 5'd4));
        tick();
        drive(1'b0, '0);
        out_ready = 1;
        repeat (4) tick();

        // Taken and not-taken branches.
        drive(1'b1, mk(0, 0, 1, 1, 64'h1000, 64'h0, 64'h0, 5'd0));
        tick();
        drive(1'b1, mk(0, 0, 1, 0, 64'h2000, 64'h0, 64'h0, 5'd0));
        tick();
        drive(1'b0, '0);
        repeat (2) tick();

        // Flush with both entries held and a new input offered.
        out_ready = 0;
        drive(1'b1, mk(1, 0, 0, 0, 64'h0, 64'h300, 64'h0, 5'd1));
        tick();
        drive(1'b1, mk(0, 1, 0, 0, 64'h0, 64'h310, 64'hCAFE, 5'd2));
        tick();
        drive(1'b1, mk(0, 1, 1, 1, 64'h4000, 64'h320, 64'hBAD, 5'd3));
        flush = 1;
        tick();
        flush = 0;
        drive(1'b0, '0);
        out_ready = 1;
        repeat (2) tick();

        // Bubble after a register write: controls drop, payload stays stale.
        drive(1'b1, mk(1, 0, 1, 1, 64'h5000, 64'h77, 64'h0, 5'd5));
        tick();
        drive(1'b0, '0);
        repeat (2) tick();

        // Reset while the skid is full.
        out_ready = 0;
        drive(1'b1, mk(1, 0, 0, 0, 64'h0, 64'h400, 64'h0, 5'd6));
        tick();
        drive(1'b1, mk(0, 1, 0, 0, 64'h0, 64'h410, 64'h0, 5'd7));
        tick();
        reset = 1;
        drive(1'b1, mk(1, 1, 1, 1, 64'h1, 64'h2, 64'h3, 5'd8));
        tick();
        reset = 0;
        drive(1'b0, '0);
        out_ready = 1;
        tick();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            e = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom));
            drive(1'($urandom_range(0, 3) != 0), e);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 0;
        drive(1'b0, '0);
        out_ready = 1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
